mux_capture_reg: RTL and testbench



---
 rtl/mux_capture_reg.sv | 83 ++++++++
 tb/tb_mux_capture_reg.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mux_capture_reg.sv
// mux_capture_reg: debounced push-button applies load/shift/rotate of the mux output into a 4-bit register
module mux_capture_reg #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W = 20
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] data_in,
   input  logic [1:0] mode,
   input  logic       btn,
   output logic [3:0] q,
   output logic       op_done,
   output logic [7:0] op_count,
   output logic       loaded,
   output logic       btn_level
);
   typedef enum logic [1:0] {RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK} state_t;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   state_t state;
   logic [1:0] syncReg;
   logic [CNT_W-1:0] cnt;
   logic btnS, fire;
   logic [3:0] nextQ;
   assign btnS = syncReg[1];
   assign fire = state == PRESS_CHK && btnS && cnt == CNT_LAST;
   assign btn_level = state == PRESSED || state == RELEASE_CHK;
   always_comb
      nextQ = mode == 2'b00 ? data_in :
              mode == 2'b01 ? {q[2:0], data_in[0]} :
              mode == 2'b10 ? {data_in[3], q[3:1]} :
                              {q[2:0], q[3]};
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         syncReg  <= '0;
         state    <= RELEASED;
         cnt      <= '0;
         q        <= '0;
         op_done  <= 1'b0;
         op_count <= '0;
         loaded   <= 1'b0;
      end else begin
         syncReg <= {syncReg[0], btn};
         op_done <= fire;
         if (fire) begin
            q        <= nextQ;
            op_count <= op_count + 8'd1;
            if (mode == 2'b00) loaded <= 1'b1;
         end
         unique case (state)
            RELEASED:
               if (btnS) begin
                  state <= PRESS_CHK;
                  cnt   <= '0;
               end
            PRESS_CHK:
               if (!btnS) begin
                  state <= RELEASED;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= PRESSED;
                  cnt   <= '0;
               end else cnt <= cnt + 1'b1;
            PRESSED:
               if (!btnS) begin
                  state <= RELEASE_CHK;
                  cnt   <= '0;
               end
            RELEASE_CHK:
               if (btnS) begin
                  state <= PRESSED;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= RELEASED;
                  cnt   <= '0;
               end else cnt <= cnt + 1'b1;
            default: begin
               state <= RELEASED;
               cnt   <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mux_capture_reg.sv
// tb_mux_capture_reg: directed table-driven checks of debounce timing and register operations
module tb_mux_capture_reg;
   logic clk = 1'b0;
   logic reset_n, btn, op_done, loaded, btn_level;
   logic [3:0] data_in, q;
   logic [1:0] mode;
   logic [7:0] op_count;
   logic [7:0] expCount;
   int errors = 0;
   int checks = 0;
   int lat;

   typedef struct {
      logic [3:0] d;
      logic [1:0] m;
      logic [3:0] q;
   } vec_t;
   vec_t vecs[7];

   always #5 clk = ~clk;

   mux_capture_reg dut (
      .clk(clk), .reset_n(reset_n), .data_in(data_in), .mode(mode), .btn(btn),
      .q(q), .op_done(op_done), .op_count(op_count), .loaded(loaded), .btn_level(btn_level)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic pressOp(input logic [3:0] d, input logic [1:0] m, output int latency);
      data_in = d;
      mode = m;
      btn = 1'b1;
      latency = 0;
      while (op_done !== 1'b1 && latency < 30) begin
         @(negedge clk);
         latency++;
      end
      data_in = ~d;
      mode = ~m;
   endtask

   task automatic releaseBtn();
      btn = 1'b0;
      repeat (10) @(negedge clk);
      check("release_level", btn_level, 0);
   endtask

   initial begin
      logic b[5];
      vecs[0] = '{4'b0000, 2'b11, 4'b0101};
      vecs[1] = '{4'b0001, 2'b01, 4'b1011};
      vecs[2] = '{4'b0111, 2'b10, 4'b0101};
      vecs[3] = '{4'b0110, 2'b00, 4'b0110};
      vecs[4] = '{4'b1110, 2'b01, 4'b1100};
      vecs[5] = '{4'b1000, 2'b10, 4'b1110};
      vecs[6] = '{4'b0000, 2'b11, 4'b1101};
      b = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

      reset_n = 1'b0; btn = 1'b0; data_in = 4'b0; mode = 2'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         btn = ~btn;
         @(negedge clk);
         check("rst_q", q, 0);
         check("rst_count", op_count, 0);
         check("rst_loaded", loaded, 0);
         check("rst_op_done", op_done, 0);
         check("rst_level", btn_level, 0);
      end
      btn = 1'b0;
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      expCount = 8'd0;

      data_in = 4'b1010; mode = 2'b00; btn = 1'b1;
      repeat (6) @(negedge clk);
      check("lat_q_before", q, 0);
      check("lat_done_before", op_done, 0);
      @(negedge clk);
      check("lat_q_edge6", q, 4'b1010);
      check("lat_done_edge6", op_done, 1);
      check("lat_count", op_count, 1);
      check("lat_loaded", loaded, 1);
      check("lat_level", btn_level, 1);
      data_in = 4'b0101; mode = 2'b01;
      @(negedge clk);
      check("done_one_cycle", op_done, 0);
      repeat (50) @(negedge clk);
      check("hold_count", op_count, 1);
      check("hold_q", q, 4'b1010);
      expCount = 8'd1;
      releaseBtn();

      for (int i = 0; i < 7; i++) begin
         pressOp(vecs[i].d, vecs[i].m, lat);
         expCount++;
         check($sformatf("vec%0d_latency", i), lat, 7);
         check($sformatf("vec%0d_q", i), q, vecs[i].q);
         check($sformatf("vec%0d_count", i), op_count, expCount);
         check($sformatf("vec%0d_loaded", i), loaded, 1);
         releaseBtn();
      end

      for (int i = 0; i < 5; i++) begin
         btn = b[i];
         @(negedge clk);
         check("bounce_level", btn_level, 0);
      end
      btn = 1'b0;
      repeat (10) @(negedge clk);
      check("bounce_level_end", btn_level, 0);
      check("bounce_count", op_count, expCount);
      check("bounce_q", q, 4'b1101);

      pressOp(4'b0011, 2'b00, lat);
      expCount++;
      check("glitch_press_q", q, 4'b0011);
      check("glitch_press_count", op_count, expCount);
      btn = 1'b0;
      repeat (2) @(negedge clk);
      btn = 1'b1;
      repeat (15) @(negedge clk);
      check("glitch_level", btn_level, 1);
      check("glitch_count", op_count, expCount);
      btn = 1'b0;
      repeat (3) @(negedge clk);
      check("release_chk_level", btn_level, 1);
      repeat (7) @(negedge clk);
      check("released_level", btn_level, 0);
      check("glitch_count_end", op_count, expCount);

      while (expCount != 8'd255) begin
         pressOp(4'b0000, 2'b11, lat);
         expCount++;
         releaseBtn();
      end
      check("pre_wrap_count", op_count, 255);
      pressOp(4'b1001, 2'b00, lat);
      check("wrap_count", op_count, 0);
      check("wrap_q", q, 4'b1001);
      releaseBtn();

      data_in = 4'b1111; mode = 2'b00; btn = 1'b1;
      repeat (4) @(negedge clk);
      reset_n = 1'b0;
      btn = 1'b0;
      @(negedge clk);
      check("midrst_q", q, 0);
      check("midrst_count", op_count, 0);
      check("midrst_loaded", loaded, 0);
      check("midrst_op_done", op_done, 0);
      check("midrst_level", btn_level, 0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (12) @(negedge clk);
      check("postrst_q", q, 0);
      check("postrst_count", op_count, 0);
      check("postrst_loaded", loaded, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
